// File: rtl/reg_access_sequencer_pkg.sv
// rtl/reg_access_sequencer_pkg.sv - shared widths, x0 index and FSM state encoding
// Purpose: common definitions for the register access sequencer.
// Contents: default XLEN/REG_AW, X0_IDX, state_e (3-bit state encoding).
package reg_access_sequencer_pkg;

  localparam int DEF_XLEN   = 64;
  localparam int DEF_REG_AW = 5;
  localparam int X0_IDX     = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD1    = 3'd1,
    ST_RD2    = 3'd2,
    ST_OPHOLD = 3'd3,
    ST_WR     = 3'd4
  } state_e;

endpackage

// File: rtl/reg_access_sequencer.sv
// rtl/reg_access_sequencer.sv - sole master of the single-port register file
// Purpose: serialises rs1/rs2 operand reads and writebacks onto one register file port,
//          returns operands over valid/ready and forces x0 reads to zero.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_req_valid/rd_req_ready  operand read request handshake, rd_rs1/rd_rs2 indices
//   op_valid/op_ready          operand return handshake, rs1_val/rs2_val
//   wb_valid/wb_ready          writeback handshake, wb_rd/wb_data
//   rf_reg_num/rf_write/rf_wdata/rf_rdata  register file port
module reg_access_sequencer
  import reg_access_sequencer_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [REG_AW-1:0] rd_rs1,
  input  logic [REG_AW-1:0] rd_rs2,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [XLEN-1:0]   rs1_val,
  output logic [XLEN-1:0]   rs2_val,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [REG_AW-1:0] rf_reg_num,
  output logic              rf_write,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [XLEN-1:0]   rf_rdata
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(X0_IDX);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] reg_num_q, reg_num_d;
  logic [REG_AW-1:0] rs2_idx_q, rs2_idx_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
  logic              op_valid_q, op_valid_d;

  logic idle;
  logic wb_hs;
  logic rd_hs;

  // Writeback has priority, so the read side only sees ready when no wb is pending.
  assign idle         = (state_q == ST_IDLE) && !reset;
  assign wb_ready     = idle;
  assign rd_req_ready = idle && !wb_valid;
  assign wb_hs        = wb_valid && wb_ready;
  assign rd_hs        = rd_req_valid && rd_req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_hs) begin
          state_d = ST_WR;
        end else if (rd_hs) begin
          state_d = ST_RD1;
        end
      end
      ST_RD1:    state_d = ST_RD2;
      ST_RD2:    state_d = ST_OPHOLD;
      ST_OPHOLD: if (op_ready) state_d = ST_IDLE;
      ST_WR:     state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-values; rf_reg_num only moves on state transitions.
  always_comb begin
    reg_num_d  = reg_num_q;
    rs2_idx_d  = rs2_idx_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    rs1_val_d  = rs1_val_q;
    rs2_val_d  = rs2_val_q;
    op_valid_d = op_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_hs) begin
          reg_num_d = wb_rd;
          wdata_d   = wb_data;
          wen_d     = (wb_rd != X0);
        end else if (rd_hs) begin
          reg_num_d = rd_rs1;
          rs2_idx_d = rd_rs2;
        end
      end
      ST_RD1: begin
        rs1_val_d = (reg_num_q == X0) ? '0 : rf_rdata;
        reg_num_d = rs2_idx_q;
      end
      ST_RD2: begin
        rs2_val_d  = (reg_num_q == X0) ? '0 : rf_rdata;
        op_valid_d = 1'b1;
      end
      ST_OPHOLD: if (op_ready) op_valid_d = 1'b0;
      ST_WR:     wen_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_num_q  <= '0;
      rs2_idx_q  <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      op_valid_q <= 1'b0;
    end else begin
      reg_num_q  <= reg_num_d;
      rs2_idx_q  <= rs2_idx_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      rs1_val_q  <= rs1_val_d;
      rs2_val_q  <= rs2_val_d;
      op_valid_q <= op_valid_d;
    end
  end

  // A reset arriving during WR must abandon the write, so the strobe is masked by reset.
  assign rf_write   = wen_q && (state_q == ST_WR) && !reset;
  assign rf_reg_num = reg_num_q;
  assign rf_wdata   = wdata_q;
  assign rs1_val    = rs1_val_q;
  assign rs2_val    = rs2_val_q;
  assign op_valid   = op_valid_q;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// tb/tb_reg_access_sequencer.sv - self-checking bench for reg_access_sequencer
module tb_reg_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rd_rs1, rd_rs2;
  logic        op_valid, op_ready;
  logic [63:0] rs1_val, rs2_val;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  rf_reg_num;
  logic        rf_write;
  logic [63:0] rf_wdata, rf_rdata;

  int total = 0;
  int bad   = 0;

  logic [63:0] rf_mem [32];
  logic [63:0] mdl [32];

  always #5 clk = ~clk;

  reg_access_sequencer dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .op_valid(op_valid), .op_ready(op_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_reg_num(rf_reg_num), .rf_write(rf_write),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  // Register file environment: combinational read, 0 while writing, no x0 protection.
  always @(posedge clk) if (rf_write) rf_mem[rf_reg_num] <= rf_wdata;
  assign rf_rdata = rf_write ? 64'd0 : rf_mem[rf_reg_num];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [63:0] d);
    wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    #1;
    total++; if (wb_ready !== 1'b1) begin bad++; $display("FAIL wb_ready_idle: got %b want 1", wb_ready); end
    step();
    wb_valid = 1'b0;
    total++; if (rf_write !== (rd != 5'd0)) begin bad++; $display("FAIL wb_rf_write rd=%0d: got %b want %b", rd, rf_write, rd != 5'd0); end
    total++; if (rf_reg_num !== rd || rf_wdata !== d) begin bad++; $display("FAIL wb_port: got idx %0d data %h want idx %0d data %h", rf_reg_num, rf_wdata, rd, d); end
    step();
    if (rd != 5'd0) mdl[rd] = d;
    total++; if (rf_write !== 1'b0 || wb_ready !== 1'b1) begin bad++; $display("FAIL wb_done: got write %b ready %b want 0 1", rf_write, wb_ready); end
  endtask

  task automatic do_read(input logic [4:0] rs1, input logic [4:0] rs2, input int hold);
    logic [63:0] e1, e2;
    e1 = (rs1 == 5'd0) ? 64'd0 : mdl[rs1];
    e2 = (rs2 == 5'd0) ? 64'd0 : mdl[rs2];
    op_ready = 1'b0;
    rd_req_valid = 1'b1; rd_rs1 = rs1; rd_rs2 = rs2;
    #1;
    total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_idle: got %b want 1", rd_req_ready); end
    step();
    rd_req_valid = 1'b0;
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL op_valid_early+1: got %b want 0", op_valid); end
    step();
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL op_valid_early+2: got %b want 0", op_valid); end
    step();
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL op_valid_latency: got %b want 1", op_valid); end
    total++; if (rs1_val !== e1 || rs2_val !== e2) begin bad++; $display("FAIL operands rs1=%0d rs2=%0d: got %h %h want %h %h", rs1, rs2, rs1_val, rs2_val, e1, e2); end
    for (int h = 0; h < hold; h++) begin
      step();
      total++;
      if (op_valid !== 1'b1 || rs1_val !== e1 || rs2_val !== e2 || rf_write !== 1'b0 || wb_ready !== 1'b0 || rd_req_ready !== 1'b0) begin
        bad++; $display("FAIL ophold_stable cyc=%0d: got v%b %h %h w%b r%b%b want v1 %h %h w0 r00", h, op_valid, rs1_val, rs2_val, rf_write, wb_ready, rd_req_ready, e1, e2);
      end
    end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    total++; if (op_valid !== 1'b0 || wb_ready !== 1'b1) begin bad++; $display("FAIL op_release: got v%b ready %b want v0 ready 1", op_valid, wb_ready); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_rs1 = '0; rd_rs2 = '0; op_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    step(); step();
    total++; if (rf_write !== 1'b0 || rf_reg_num !== 5'd0 || rf_wdata !== 64'd0) begin bad++; $display("FAIL reset_rf: got %b %0d %h want 0 0 0", rf_write, rf_reg_num, rf_wdata); end
    total++; if (op_valid !== 1'b0 || rs1_val !== 64'd0 || rs2_val !== 64'd0) begin bad++; $display("FAIL reset_op: got %b %h %h want 0 0 0", op_valid, rs1_val, rs2_val); end
    total++; if (wb_ready !== 1'b0 || rd_req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b %b want 0 0", wb_ready, rd_req_ready); end
    reset = 1'b0;
    #1;
    total++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b %b want 1 1", wb_ready, rd_req_ready); end
  endtask

  task automatic test_reset_midop();
    rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd4; op_ready = 1'b0;
    step();
    rd_req_valid = 1'b0;
    step(); step();
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL midop_reach_ophold: got %b want 1", op_valid); end
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (op_valid !== 1'b0 || rf_write !== 1'b0 || wb_ready !== 1'b1 || rd_req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_midop: got v%b w%b r%b%b want v0 w0 r11", op_valid, rf_write, wb_ready, rd_req_ready);
    end
    // Reset landing on the WR cycle must drop the write.
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h1111_2222_3333_4444;
    step();
    wb_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_wr_strobe: got %b want 0", rf_write); end
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (rf_mem[7] !== mdl[7]) begin bad++; $display("FAIL reset_wr_dropped: got %h want %h", rf_mem[7], mdl[7]); end
  endtask

  task automatic test_wb_then_read();
    do_wb(5'd5, 64'hDEAD_BEEF_0123_4567);
    do_read(5'd5, 5'd0, 0);
  endtask

  task automatic test_x0();
    do_wb(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_read(5'd0, 5'd5, 0);
    do_read(5'd0, 5'd0, 1);
  endtask

  task automatic test_arbitration();
    logic [63:0] d;
    d = {$urandom, $urandom};
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = d;
    rd_req_valid = 1'b1; rd_rs1 = 5'd9; rd_rs2 = 5'd3;
    #1;
    total++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b0) begin bad++; $display("FAIL arb_ready: got wb %b rd %b want 1 0", wb_ready, rd_req_ready); end
    step();
    wb_valid = 1'b0;
    #1;
    total++; if (rf_write !== 1'b1 || rd_req_ready !== 1'b0) begin bad++; $display("FAIL arb_wr_first: got w%b rd %b want 1 0", rf_write, rd_req_ready); end
    step();
    mdl[9] = d;
    total++; if (rd_req_ready !== 1'b1) begin bad++; $display("FAIL arb_rd_next_idle: got %b want 1", rd_req_ready); end
    step();
    rd_req_valid = 1'b0;
    step(); step();
    total++; if (op_valid !== 1'b1 || rs1_val !== d || rs2_val !== mdl[3]) begin
      bad++; $display("FAIL arb_read_sees_wb: got v%b %h %h want v1 %h %h", op_valid, rs1_val, rs2_val, d, mdl[3]);
    end
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
  endtask

  task automatic test_ophold_stall();
    do_read(5'd11, 5'd12, 5);
  endtask

  task automatic test_back_to_back();
    int pulses, last;
    pulses = 0; last = -1;
    op_ready = 1'b1;
    rd_req_valid = 1'b1; rd_rs1 = 5'd1; rd_rs2 = 5'd2;
    for (int s = 1; s <= 24; s++) begin
      step();
      if (op_valid === 1'b1) begin
        pulses++;
        total++; if (rs1_val !== mdl[1] || rs2_val !== mdl[2]) begin bad++; $display("FAIL b2b_values: got %h %h want %h %h", rs1_val, rs2_val, mdl[1], mdl[2]); end
        if (last >= 0) begin
          total++; if (s - last != 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", s - last); end
        end
        last = s;
      end
    end
    rd_req_valid = 1'b0;
    step();
    op_ready = 1'b0;
    total++; if (pulses != 6) begin bad++; $display("FAIL b2b_count: got %0d want 6", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        logic [4:0] rd;
        rd = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
        do_wb(rd, {$urandom, $urandom});
      end else begin
        do_read(5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), $urandom_range(3, 0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = {$urandom, $urandom} | 64'h1;
      mdl[i]    = rf_mem[i];
    end
    mdl[0] = 64'd0;
    test_reset();
    test_reset_midop();
    test_wb_then_read();
    test_x0();
    test_arbitration();
    test_ophold_stall();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
